// File: rtl/img_fetch_seq.sv
// img_fetch_seq: fetches the 2x2 neighbour quad around (x,y) from a 1-cycle-latency image memory,
// clamping coordinates to the image, and hands the quad plus fractions downstream.
module img_fetch_seq #(
    parameter int ADDR_W = 19,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [9:0]        req_x,
    input  logic [9:0]        req_y,
    input  logic [7:0]        req_fx,
    input  logic [7:0]        req_fy,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [7:0]        mem_rdata,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [7:0]        p00,
    output logic [7:0]        p01,
    output logic [7:0]        p10,
    output logic [7:0]        p11,
    output logic [7:0]        px_fx,
    output logic [7:0]        px_fy,
    output logic              busy,
    output logic [15:0]       pix_count
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, CAP, OUT} state_t;
    state_t state, state_nx;
    logic [9:0]  x_q, y_q;
    logic [31:0] xc, yc, x1, y1, row, col;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_valid ? RD0 : IDLE;
            RD0:     state_nx = RD1;
            RD1:     state_nx = RD2;
            RD2:     state_nx = RD3;
            RD3:     state_nx = CAP;
            CAP:     state_nx = OUT;
            OUT:     state_nx = px_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end
    // clamp in 32 bits so the +1 on the far edge cannot wrap
    always_comb begin
        xc = ({22'd0, x_q} > 32'(IMG_W - 1)) ? 32'(IMG_W - 1) : {22'd0, x_q};
        yc = ({22'd0, y_q} > 32'(IMG_H - 1)) ? 32'(IMG_H - 1) : {22'd0, y_q};
        x1 = (xc + 32'd1 > 32'(IMG_W - 1)) ? 32'(IMG_W - 1) : xc + 32'd1;
        y1 = (yc + 32'd1 > 32'(IMG_H - 1)) ? 32'(IMG_H - 1) : yc + 32'd1;
        col = (state == RD1 || state == RD3) ? x1 : xc;
        row = (state == RD2 || state == RD3) ? y1 : yc;
        mem_raddr = ADDR_W'(row * 32'(IMG_W) + col);
    end
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign px_valid  = (state == OUT);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            px_fx     <= '0;
            px_fy     <= '0;
            p00       <= '0;
            p01       <= '0;
            p10       <= '0;
            p11       <= '0;
            pix_count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                x_q   <= req_x;
                y_q   <= req_y;
                px_fx <= req_fx;
                px_fy <= req_fy;
            end
            // read data lags its address by one state
            if (state == RD1) p00 <= mem_rdata;
            if (state == RD2) p01 <= mem_rdata;
            if (state == RD3) p10 <= mem_rdata;
            if (state == CAP) p11 <= mem_rdata;
            if (state == OUT && px_ready) pix_count <= pix_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_img_fetch_seq.sv
// tb_img_fetch_seq: directed checks of the quad fetch sequencer against a mem[a]=a[7:0] memory.
module tb_img_fetch_seq;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready, px_valid, px_ready = 1, busy;
    logic [9:0]  req_x = 0, req_y = 0;
    logic [7:0]  req_fx = 0, req_fy = 0, mem_rdata = 0;
    logic [7:0]  p00, p01, p10, p11, px_fx, px_fy;
    logic [18:0] mem_raddr;
    logic [15:0] pix_count;
    int checks = 0, failures = 0;

    img_fetch_seq #(.ADDR_W(19), .IMG_W(640), .IMG_H(480)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_fx(req_fx), .req_fy(req_fy),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .px_valid(px_valid),
        .px_ready(px_ready), .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .px_fx(px_fx), .px_fy(px_fy), .busy(busy), .pix_count(pix_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_rdata <= mem_raddr[7:0];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int x, input int y, input int fx, input int fy,
                         input int a0, input int a1, input int a2, input int a3,
                         input int e00, input int e01, input int e10, input int e11,
                         input int cnt_before, input bit release_out);
        req_x = 10'(x); req_y = 10'(y); req_fx = 8'(fx); req_fy = 8'(fy);
        req_valid = 1;
        chk("ready_idle", req_ready, 1);
        tick();
        req_valid = 0;
        chk("busy_rd0", busy, 1);
        chk("ready_rd0", req_ready, 0);
        chk("addr_rd0", mem_raddr, a0);
        tick();
        chk("addr_rd1", mem_raddr, a1);
        tick();
        chk("addr_rd2", mem_raddr, a2);
        tick();
        chk("addr_rd3", mem_raddr, a3);
        tick();
        chk("pxv_cap", px_valid, 0);
        tick();
        chk("pxv_out", px_valid, 1);
        chk("p00", p00, e00);
        chk("p01", p01, e01);
        chk("p10", p10, e10);
        chk("p11", p11, e11);
        chk("px_fx", px_fx, fx);
        chk("px_fy", px_fy, fy);
        chk("cnt_out", pix_count, cnt_before);
        if (release_out) begin
            tick();
            chk("ready_after", req_ready, 1);
            chk("cnt_after", pix_count, (cnt_before + 1) & 16'hFFFF);
        end
    endtask

    initial begin
        #2;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pxv", px_valid, 0);
        chk("rst_addr", mem_raddr, 0);
        chk("rst_cnt", pix_count, 0);
        chk("rst_p00", p00, 0);
        tick();
        rst = 0;
        tick();
        fetch(10, 20, 8'h33, 8'h44, 12810, 12811, 13450, 13451, 8'h0A, 8'h0B, 8'h8A, 8'h8B, 0, 1);
        chk("idle_addr_hold", mem_raddr, 12810);
        fetch(639, 0, 8'h01, 8'h02, 639, 639, 1279, 1279, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 1, 1);
        fetch(700, 479, 8'hA5, 8'h5A, 307199, 307199, 307199, 307199, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2, 1);
        px_ready = 0;
        fetch(10, 20, 8'h12, 8'h34, 12810, 12811, 13450, 13451, 8'h0A, 8'h0B, 8'h8A, 8'h8B, 3, 0);
        req_x = 10'd5; req_y = 10'd5; req_fx = 8'hEE; req_fy = 8'hEE; req_valid = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_pxv", px_valid, 1);
            chk("bp_ready", req_ready, 0);
            chk("bp_p11", p11, 8'h8B);
            chk("bp_fx", px_fx, 8'h12);
        end
        req_valid = 0;
        px_ready = 1;
        tick();
        chk("bp_release_ready", req_ready, 1);
        chk("bp_release_pxv", px_valid, 0);
        chk("bp_cnt", pix_count, 4);
        chk("bp_not_taken", mem_raddr, 12810);
        req_x = 10'd3; req_y = 10'd3; req_fx = 8'h77; req_valid = 1;
        tick();
        req_valid = 0;
        tick();
        tick();
        chk("rd2_busy", busy, 1);
        rst = 1;
        #1;
        chk("arst_pxv", px_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", req_ready, 1);
        chk("arst_addr", mem_raddr, 0);
        chk("arst_p00", p00, 0);
        chk("arst_fx", px_fx, 0);
        chk("arst_cnt", pix_count, 0);
        tick();
        rst = 0;
        tick();
        chk("post_rst_cnt", pix_count, 0);
        fetch(1, 1, 8'h10, 8'h20, 641, 642, 1281, 1282, 8'h81, 8'h82, 8'h01, 8'h02, 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
